// File: rtl/fast_irq_ctrl.sv
// -----------------------------------------------------------------------------
// fast_irq_ctrl
//
// Fast-interrupt controller that feeds the core's 16-bit fast-interrupt input.
// Sixteen peripheral sources are synchronized, then edge- or level-detected
// per line and latched into PENDING. The output is PENDING masked by ENABLE.
// Software reaches PENDING/ENABLE/MODE/SET through a req/gnt/rvalid register
// slave that is always ready and answers one cycle after acceptance.
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   req_i      register request (accepted every cycle it is high)
//   gnt_o      grant, equal to req_i
//   addr_i     byte address, bits [11:0] decoded
//   we_i       write enable
//   be_i       byte enables, lanes 0 and 1 used
//   wdata_i    write data, bits [15:0] used
//   rvalid_o   response valid, one cycle after acceptance
//   rdata_o    read data (0 for writes and errors)
//   err_o      error response for unmapped offsets, qualified by rvalid_o
//   irq_src_i  raw interrupt sources, may be asynchronous
//   irqs_o     pending & enable, driven from flops only
//
// Register map (offset = addr_i[11:0]):
//   0x0 PENDING  R/W1C
//   0x4 ENABLE   RW
//   0x8 MODE     RW, 1 = edge, 0 = level
//   0xC SET      write-1-to-set PENDING, reads 0
//   0x10..0xFFF  unmapped, error response, no state change
// -----------------------------------------------------------------------------
module fast_irq_ctrl #(
    parameter int unsigned SyncStages = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic [15:0] irq_src_i,
    output logic [15:0] irqs_o
);

    logic [15:0] w_s;
    logic [15:0] r_s_q;
    logic [15:0] r_pending;
    logic [15:0] r_enable;
    logic [15:0] r_mode;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [11:0] w_off;
    logic        w_mapped;
    logic [1:0]  w_sel;
    logic        w_wr;
    logic [15:0] w_bemask;
    logic [15:0] w_wbits;
    logic [15:0] w_pend_set;
    logic [15:0] w_pend_clr;
    logic [15:0] w_pend_d;
    logic [15:0] w_en_d;
    logic [15:0] w_mode_d;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Source synchronizer: a plain wire when the sources are already synchronous.
    generate
        if (SyncStages == 0) begin : g_nosync
            assign w_s = irq_src_i;
        end else begin : g_sync
            localparam int unsigned SyncW = 16 * SyncStages;
            logic [SyncW-1:0] r_sync;

            // Shift chain, newest sample in the low 16 bits.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_sync <= {SyncW{1'b0}};
                end else begin
                    r_sync <= SyncW'({r_sync, irq_src_i});
                end
            end

            assign w_s = r_sync[SyncW-1 -: 16];
        end
    endgenerate

    assign w_off    = addr_i[11:0];
    assign w_mapped = (w_off[11:4] == 8'h00);
    assign w_sel    = w_off[3:2];
    assign w_wr     = req_i & we_i & w_mapped;
    assign w_bemask = {{8{be_i[1]}}, {8{be_i[0]}}};
    assign w_wbits  = wdata_i[15:0] & w_bemask;

    // Bits that are ignored by the decoder or the 16-bit register layout.
    assign w_unused = ^{addr_i[31:12], w_off[1:0], be_i[3:2], wdata_i[31:16]};

    // Register next-state; a hardware or SET-register set beats a W1C clear.
    always_comb begin
        w_pend_set = (r_mode & w_s & ~r_s_q) | (~r_mode & w_s);
        w_pend_clr = 16'h0000;
        w_en_d     = r_enable;
        w_mode_d   = r_mode;
        if (w_wr) begin
            case (w_sel)
                2'd0:    w_pend_clr = w_wbits;
                2'd1:    w_en_d     = (r_enable & ~w_bemask) | w_wbits;
                2'd2:    w_mode_d   = (r_mode & ~w_bemask) | w_wbits;
                2'd3:    w_pend_set = w_pend_set | w_wbits;
                default: w_pend_clr = 16'h0000;
            endcase
        end else begin
            w_pend_clr = 16'h0000;
        end
        w_pend_d = w_pend_set | (r_pending & ~w_pend_clr);
    end

    // Read mux; samples register values before this cycle's update.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (req_i && !we_i && w_mapped) begin
            case (w_sel)
                2'd0:    w_rdata = {16'h0000, r_pending};
                2'd1:    w_rdata = {16'h0000, r_enable};
                2'd2:    w_rdata = {16'h0000, r_mode};
                default: w_rdata = 32'h0000_0000;
            endcase
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    // State and registered bus response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s_q     <= 16'h0000;
            r_pending <= 16'h0000;
            r_enable  <= 16'h0000;
            r_mode    <= 16'h0000;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'h0000_0000;
            r_err     <= 1'b0;
        end else begin
            r_s_q     <= w_s;
            r_pending <= w_pend_d;
            r_enable  <= w_en_d;
            r_mode    <= w_mode_d;
            r_rvalid  <= req_i;
            r_rdata   <= w_rdata;
            r_err     <= req_i & ~w_mapped;
        end
    end

    assign gnt_o    = req_i;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;
    assign irqs_o   = r_pending & r_enable;

endmodule

// File: tb/tb_fast_irq_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for fast_irq_ctrl. A reference model updates at each clock edge
// from the bus and source inputs, pushing expected responses into a queue;
// a monitor 2 time units after each rising edge pops and compares responses
// and checks irqs_o and gnt_o every cycle. Directed scenarios add explicit
// timing checks, then a randomized phase runs against the model.
// -----------------------------------------------------------------------------
module tb_fast_irq_ctrl;

    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [3:0]  be_i = 4'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [15:0] irq_src_i = 16'h0;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [15:0] irqs_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t exp_q[$];

    // Reference model state
    logic [15:0] m_pend, m_en, m_mode, m_sq, m_s, m_np, m_mask, m_wb;
    logic [15:0] m_samp [4];
    int          m_off;
    logic        m_is_wr;
    resp_t       m_r;
    resp_t       mon_r;

    always #5 clk = ~clk;

    fast_irq_ctrl #(.SyncStages(SS)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .irq_src_i(irq_src_i),
        .irqs_o   (irqs_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference model: applies the pending/enable/mode rules once per clock.
    initial begin
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) begin
                m_pend = 16'h0;
                m_en   = 16'h0;
                m_mode = 16'h0;
                m_sq   = 16'h0;
                for (int j = 0; j < 4; j++) m_samp[j] = 16'h0;
                exp_q.delete();
            end else begin
                m_s = (SS == 0) ? irq_src_i : m_samp[SS-1];
                m_off = int'(addr_i[11:0]);
                m_mask = 16'h0;
                if (be_i[0]) m_mask[7:0]  = 8'hFF;
                if (be_i[1]) m_mask[15:8] = 8'hFF;
                m_wb = wdata_i[15:0] & m_mask;
                m_is_wr = req_i && we_i && (m_off < 16);
                if (req_i) begin
                    m_r.err  = (m_off >= 16);
                    m_r.data = 32'h0;
                    if (!we_i && m_off < 16) begin
                        if (m_off / 4 == 0)      m_r.data = {16'h0, m_pend};
                        else if (m_off / 4 == 1) m_r.data = {16'h0, m_en};
                        else if (m_off / 4 == 2) m_r.data = {16'h0, m_mode};
                    end
                    exp_q.push_back(m_r);
                end
                for (int i = 0; i < 16; i++) begin
                    if (m_mode[i] ? (m_s[i] && !m_sq[i]) : m_s[i])          m_np[i] = 1'b1;
                    else if (m_is_wr && m_off / 4 == 3 && m_wb[i])         m_np[i] = 1'b1;
                    else if (m_is_wr && m_off / 4 == 0 && m_wb[i])         m_np[i] = 1'b0;
                    else                                                   m_np[i] = m_pend[i];
                end
                m_pend = m_np;
                if (m_is_wr && m_off / 4 == 1) m_en   = (m_en & ~m_mask) | m_wb;
                if (m_is_wr && m_off / 4 == 2) m_mode = (m_mode & ~m_mask) | m_wb;
                m_sq = m_s;
                for (int j = 3; j > 0; j--) m_samp[j] = m_samp[j-1];
                m_samp[0] = irq_src_i;
            end
        end
    end

    // Monitor: compares DUT outputs against the model shortly after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst_ni) begin
                check("gnt", {31'h0, gnt_o}, {31'h0, req_i});
                check("irqs", {16'h0, irqs_o}, {16'h0, m_pend & m_en});
                if (rvalid_o) begin
                    if (exp_q.size() == 0) begin
                        check("rvalid_unexpected", {31'h0, rvalid_o}, 32'h0);
                    end else begin
                        mon_r = exp_q.pop_front();
                        check("resp_err", {31'h0, err_o}, {31'h0, mon_r.err});
                        check("resp_rdata", rdata_o, mon_r.data);
                    end
                end else begin
                    check("idle_rdata", rdata_o, 32'h0);
                    check("idle_err", {31'h0, err_o}, 32'h0);
                    if (exp_q.size() != 0) begin
                        check("rvalid_missing", {31'h0, rvalid_o}, 32'h1);
                        exp_q.delete();
                    end
                end
            end
        end
    end

    task automatic acc(input logic we, input logic [11:0] off, input logic [31:0] d, input logic [3:0] be);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = {20'h0, off};
        wdata_i = d;
        be_i    = be;
    endtask

    task automatic idle();
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = 32'h0;
        wdata_i = 32'h0;
        be_i    = 4'h0;
    endtask

    task automatic wr(input logic [11:0] off, input logic [31:0] d, input logic [3:0] be);
        acc(1'b1, off, d, be);
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input logic [11:0] off, output logic [31:0] data);
        acc(1'b0, off, 32'h0, 4'hF);
        @(negedge clk);
        idle();
        data = rdata_o;
    endtask

    logic [31:0] d;
    logic        b2b_we  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [11:0] b2b_off [4] = '{12'h004, 12'h010, 12'h008, 12'h008};
    logic        b2b_err [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int          sel;
    logic [11:0] roff;

    initial begin
        // Reset state, with a request held to see gnt follow it.
        req_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_irqs", {16'h0, irqs_o}, 32'h0);
        check("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_err", {31'h0, err_o}, 32'h0);
        check("rst_gnt", {31'h0, gnt_o}, 32'h1);
        idle();
        rst_ni = 1'b1;
        @(negedge clk);

        // Edge latch and W1C
        wr(12'h008, 32'h0000_FFFF, 4'h3);
        wr(12'h004, 32'h0000_0001, 4'h3);
        irq_src_i[0] = 1'b1;
        @(negedge clk);
        irq_src_i[0] = 1'b0;
        @(negedge clk);
        check("edge_lat1", {16'h0, irqs_o}, 32'h0);
        @(negedge clk);
        check("edge_lat2", {16'h0, irqs_o}, 32'h1);
        repeat (3) @(negedge clk);
        check("edge_hold", {16'h0, irqs_o}, 32'h1);
        wr(12'h000, 32'h0000_0001, 4'h3);
        check("edge_w1c", {16'h0, irqs_o}, 32'h0);

        // Level re-assert
        wr(12'h008, 32'h0, 4'h3);
        wr(12'h004, 32'h0000_8000, 4'h3);
        irq_src_i[15] = 1'b1;
        repeat (4) @(negedge clk);
        check("lvl_set", {16'h0, irqs_o}, 32'h8000);
        wr(12'h000, 32'h0000_8000, 4'h3);
        check("lvl_reassert", {16'h0, irqs_o}, 32'h8000);
        irq_src_i[15] = 1'b0;
        repeat (3) @(negedge clk);
        check("lvl_held", {16'h0, irqs_o}, 32'h8000);
        wr(12'h000, 32'h0000_8000, 4'h3);
        check("lvl_clear", {16'h0, irqs_o}, 32'h0);

        // Enable masking
        wr(12'h004, 32'h0, 4'h3);
        wr(12'h008, 32'h0000_FFFF, 4'h3);
        irq_src_i[3] = 1'b1;
        @(negedge clk);
        irq_src_i[3] = 1'b0;
        repeat (4) @(negedge clk);
        rd(12'h000, d);
        check("mask_pend", d, 32'h0008);
        check("mask_irqs", {16'h0, irqs_o}, 32'h0);
        wr(12'h004, 32'h0000_0008, 4'h3);
        check("mask_en", {16'h0, irqs_o}, 32'h0008);

        // Software set and byte enables
        wr(12'h000, 32'h0000_FFFF, 4'h3);
        wr(12'h00C, 32'h0000_FFFF, 4'b0010);
        check("set_rvalid", {31'h0, rvalid_o}, 32'h1);
        check("set_err", {31'h0, err_o}, 32'h0);
        check("set_wr_rdata", rdata_o, 32'h0);
        rd(12'h000, d);
        check("set_pend", d, 32'hFF00);
        rd(12'h00C, d);
        check("set_read0", d, 32'h0);
        wr(12'h004, 32'hFFFF_FFFF, 4'b0001);
        rd(12'h004, d);
        check("be_enable", d, 32'h00FF);

        // Simultaneous rising edge and W1C on bit 2
        wr(12'h000, 32'h0000_FFFF, 4'h3);
        irq_src_i[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wr(12'h000, 32'h0000_0004, 4'h3);
        irq_src_i[2] = 1'b0;
        rd(12'h000, d);
        check("simul_set_wins", d, 32'h0004);

        // Errors and back-to-back requests
        for (int i = 0; i < 4; i++) begin
            acc(b2b_we[i], b2b_off[i], 32'h0000_0005, 4'h3);
            @(negedge clk);
            check("b2b_rvalid", {31'h0, rvalid_o}, 32'h1);
            check("b2b_err", {31'h0, err_o}, {31'h0, b2b_err[i]});
        end
        idle();
        check("b2b_last_rdata", rdata_o, 32'h5);

        // Reset mid-burst
        wr(12'h00C, 32'h0000_00FF, 4'h3);
        acc(1'b0, 12'h000, 32'h0, 4'hF);
        @(negedge clk);
        acc(1'b0, 12'h004, 32'h0, 4'hF);
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_rvalid", {31'h0, rvalid_o}, 32'h0);
        check("mid_rst_rdata", rdata_o, 32'h0);
        check("mid_rst_err", {31'h0, err_o}, 32'h0);
        check("mid_rst_irqs", {16'h0, irqs_o}, 32'h0);
        idle();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        rd(12'h004, d);
        check("post_rst_enable", d, 32'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0)
                irq_src_i = irq_src_i ^ (16'(1) << $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                sel = $urandom_range(0, 4);
                if (sel < 4) roff = 12'(sel * 4);
                else         roff = 12'(16 + $urandom_range(0, 4079));
                acc(1'($urandom_range(0, 1)), roff, $urandom, 4'($urandom_range(0, 15)));
                addr_i[31:12] = 20'($urandom);
            end else begin
                idle();
            end
        end
        idle();
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
